// File: rtl/bsram_port_arbiter.sv
// rtl/bsram_port_arbiter.sv - imem/dmem arbiter sharing one single-port BSRAM with 1-cycle read latency
// dmem has priority; imem wins once it has stalled STARVE_MAX consecutive cycles.
module bsram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic                imem_gnt,
  output logic                imem_rvalid,
  output logic [DATA_W-1:0]   imem_rdata,
  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [DATA_W/8-1:0] dmem_be,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_gnt,
  output logic                dmem_rvalid,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_e;

  owner_e            rd_owner_q, rd_owner_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] imem_hold_q, imem_hold_d;
  logic [DATA_W-1:0] dmem_hold_q, dmem_hold_d;
  logic              imem_win, dmem_win;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    imem_win = 1'b0;
    dmem_win = 1'b0;
    if (rst_n) begin
      if (dmem_req && !(imem_req && (starve_q == STARVE_LIM))) begin
        dmem_win = 1'b1;
      end else if (imem_req) begin
        imem_win = 1'b1;
      end
    end
  end

  assign imem_gnt  = imem_win;
  assign dmem_gnt  = dmem_win;
  assign mem_en    = imem_win | dmem_win;
  assign mem_we    = dmem_win & dmem_we;
  assign mem_be    = mem_we ? dmem_be : (mem_en ? {BE_W{1'b1}} : {BE_W{1'b0}});
  assign mem_addr  = dmem_win ? dmem_addr : imem_addr;
  assign mem_wdata = dmem_wdata;

  // A return landing in a reset cycle is dropped by qualifying rvalid with rst_n.
  always_comb begin
    rd_owner_d  = OWN_NONE;
    imem_rvalid = rst_n && (rd_owner_q == OWN_IMEM);
    dmem_rvalid = rst_n && (rd_owner_q == OWN_DMEM);
    if (imem_win) begin
      rd_owner_d = OWN_IMEM;
    end else if (dmem_win && !dmem_we) begin
      rd_owner_d = OWN_DMEM;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (imem_win) begin
      starve_d = 4'd0;
    end else if (imem_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign imem_hold_d = imem_rvalid ? mem_rdata : imem_hold_q;
  assign dmem_hold_d = dmem_rvalid ? mem_rdata : dmem_hold_q;
  assign imem_rdata  = imem_hold_d;
  assign dmem_rdata  = dmem_hold_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner_q  <= OWN_NONE;
      starve_q    <= 4'd0;
      imem_hold_q <= '0;
      dmem_hold_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      starve_q    <= starve_d;
      imem_hold_q <= imem_hold_d;
      dmem_hold_q <= dmem_hold_d;
    end
  end

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// tb/tb_bsram_port_arbiter.sv - self-checking bench for bsram_port_arbiter
// Behavioural RAM macro plus a per-cycle reference model and directed literal checks.
module tb_bsram_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt, imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_req, dmem_we;
  logic [3:0]        dmem_be;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt, dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  bsram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    case (a)
      'h010:   return 32'hDEADBEEF;
      'h020:   return 32'h12345678;
      'h005:   return 32'h11111111;
      default: return 32'hA5000000 | a;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM macro: 1-cycle read latency, byte-masked writes.
  logic [DATA_W-1:0] ram [DEPTH];
  logic              ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model: arbitration rules, read-return queue of depth one per requester, held data.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_loaded = 1'b0;
  int                m_starve;
  logic              m_pend_i, m_pend_d, mi_g, md_g, e_iv, e_dv;
  logic [DATA_W-1:0] m_pdata_i, m_pdata_d, m_hold_i, m_hold_d;

  always @(negedge clk) begin
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
      m_starve = 0; m_pend_i = 0; m_pend_d = 0; m_hold_i = '0; m_hold_d = '0;
      m_pdata_i = '0; m_pdata_d = '0;
    end
    mi_g = 1'b0;
    md_g = 1'b0;
    if (rst_n) begin
      if (imem_req && dmem_req) begin
        mi_g = (m_starve == STARVE_MAX);
        md_g = !mi_g;
      end else begin
        mi_g = imem_req;
        md_g = dmem_req;
      end
    end
    e_iv = rst_n && m_pend_i;
    e_dv = rst_n && m_pend_d;
    chk("imem_gnt", imem_gnt, mi_g);
    chk("dmem_gnt", dmem_gnt, md_g);
    chk("mem_en", mem_en, mi_g | md_g);
    chk("imem_rvalid", imem_rvalid, e_iv);
    chk("dmem_rvalid", dmem_rvalid, e_dv);
    chk("imem_rdata", imem_rdata, e_iv ? m_pdata_i : m_hold_i);
    chk("dmem_rdata", dmem_rdata, e_dv ? m_pdata_d : m_hold_d);
    if (!rst_n) begin
      chk("mem_we_rst", mem_we, 1'b0);
      chk("mem_be_rst", mem_be, 4'h0);
    end
    if (mi_g || md_g) begin
      chk("mem_addr", mem_addr, md_g ? dmem_addr : imem_addr);
      chk("mem_we", mem_we, md_g && dmem_we);
      chk("mem_be", mem_be, (md_g && dmem_we) ? dmem_be : 4'hF);
      if (md_g && dmem_we) chk("mem_wdata", mem_wdata, dmem_wdata);
    end
    if (!rst_n) begin
      m_starve = 0; m_pend_i = 0; m_pend_d = 0; m_hold_i = '0; m_hold_d = '0;
    end else begin
      if (e_iv) m_hold_i = m_pdata_i;
      if (e_dv) m_hold_d = m_pdata_d;
      m_pend_i = mi_g;
      if (mi_g) m_pdata_i = ref_mem[imem_addr];
      m_pend_d = md_g && !dmem_we;
      if (m_pend_d) m_pdata_d = ref_mem[dmem_addr];
      if (md_g && dmem_we)
        for (int b = 0; b < 4; b++)
          if (dmem_be[b]) ref_mem[dmem_addr][8*b +: 8] = dmem_wdata[8*b +: 8];
      if (mi_g) m_starve = 0;
      else if (imem_req && m_starve < STARVE_MAX) m_starve++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req = 1'b1; imem_addr = '0;
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_be = 4'hF; dmem_addr = '0; dmem_wdata = '0;
    // Reset: requests present but nothing may be granted.
    mid();
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_imem_gnt", imem_gnt, 1'b0);
    chk("rst_dmem_gnt", dmem_gnt, 1'b0);
    next_cycle();
    rst_n = 1'b1; imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
    mid();
    chk("post_rst_irvalid", imem_rvalid, 1'b0);
    chk("post_rst_irdata", imem_rdata, 32'h0);
    chk("post_rst_drdata", dmem_rdata, 32'h0);
    next_cycle();

    // Single imem read.
    imem_req = 1'b1; imem_addr = 12'h010;
    mid();
    chk("ird_gnt", imem_gnt, 1'b1);
    chk("ird_mem_en", mem_en, 1'b1);
    chk("ird_mem_addr", mem_addr, 12'h010);
    next_cycle();
    imem_req = 1'b0;
    mid();
    chk("ird_rvalid", imem_rvalid, 1'b1);
    chk("ird_rdata", imem_rdata, 32'hDEADBEEF);
    next_cycle();
    mid();
    chk("ird_rvalid_off", imem_rvalid, 1'b0);
    chk("ird_hold", imem_rdata, 32'hDEADBEEF);
    next_cycle();

    // Contention: dmem wins first, imem next cycle.
    imem_req = 1'b1; imem_addr = 12'h003;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 12'h020;
    mid();
    chk("cont_dgnt0", dmem_gnt, 1'b1);
    chk("cont_ignt0", imem_gnt, 1'b0);
    next_cycle();
    dmem_req = 1'b0;
    mid();
    chk("cont_drvalid1", dmem_rvalid, 1'b1);
    chk("cont_drdata1", dmem_rdata, 32'h12345678);
    chk("cont_ignt1", imem_gnt, 1'b1);
    next_cycle();
    imem_req = 1'b0;
    mid();
    chk("cont_irvalid2", imem_rvalid, 1'b1);
    chk("cont_irdata2", imem_rdata, 32'hA5000003);
    next_cycle();

    // Starvation: imem forced through at cycles 4 and 9.
    imem_req = 1'b1; imem_addr = 12'h010;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 12'h020;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk($sformatf("starve_ignt_c%0d", k), imem_gnt, (k == 4 || k == 9));
      chk($sformatf("starve_dgnt_c%0d", k), dmem_gnt, !(k == 4 || k == 9));
      next_cycle();
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    next_cycle();

    // Partial dmem write then read-back.
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 12'h005; dmem_be = 4'b0011;
    dmem_wdata = 32'hAABBCCDD;
    mid();
    chk("wr_gnt", dmem_gnt, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_be", mem_be, 4'b0011);
    next_cycle();
    dmem_we = 1'b0; dmem_be = 4'hF;
    mid();
    chk("wr_no_rvalid", dmem_rvalid, 1'b0);
    chk("rb_gnt", dmem_gnt, 1'b1);
    next_cycle();
    dmem_req = 1'b0;
    mid();
    chk("rb_rvalid", dmem_rvalid, 1'b1);
    chk("rb_rdata", dmem_rdata, 32'h1111CCDD);
    next_cycle();

    // Back-to-back imem fetches, one per cycle.
    for (int k = 0; k < 5; k++) begin
      imem_req = (k < 4);
      imem_addr = ADDR_W'(k);
      mid();
      if (k < 4) chk($sformatf("b2b_gnt_c%0d", k), imem_gnt, 1'b1);
      if (k > 0) begin
        chk($sformatf("b2b_rvalid_c%0d", k), imem_rvalid, 1'b1);
        chk($sformatf("b2b_rdata_c%0d", k), imem_rdata, 32'hA5000000 + 32'(k - 1));
      end
      next_cycle();
    end
    imem_req = 1'b0;
    next_cycle();

    // Reset arriving the cycle after an imem grant discards the return.
    imem_req = 1'b1; imem_addr = 12'h010;
    mid();
    chk("rstm_gnt", imem_gnt, 1'b1);
    next_cycle();
    rst_n = 1'b0; imem_req = 1'b0;
    mid();
    chk("rstm_rvalid_n1", imem_rvalid, 1'b0);
    chk("rstm_mem_en", mem_en, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    mid();
    chk("rstm_rvalid_n2", imem_rvalid, 1'b0);
    chk("rstm_rdata", imem_rdata, 32'h0);
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsram_port_arbiter.md
Name: bsram_port_arbiter

Overview:
- Shares one single-port synchronous block RAM (1-cycle read latency) between the SCR1 instruction-fetch requester (imem, read-only) and the data requester (dmem, read/write with byte enables).
- Sits between the core-side imem/dmem bridges and the BSRAM macro. It replaces a true-dual-port arrangement when the BSRAM must be configured single-port to fit RAM images.
- Provides a request/grant/rvalid handshake per requester, dmem priority, and an anti-starvation guarantee for imem.

Parameters:
- ADDR_W, 12, word-address width of the RAM (depth = 2**ADDR_W words).
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_MAX, 4, consecutive stalled imem cycles after which imem wins arbitration; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- imem_req  in  1  imem read request; addr stable while req=1 and gnt=0
- imem_addr  in  ADDR_W  imem word address
- imem_gnt  out  1  imem request accepted this cycle (combinational)
- imem_rvalid  out  1  imem_rdata valid (cycle after grant)
- imem_rdata  out  DATA_W  imem read data
- dmem_req  in  1  dmem request
- dmem_we  in  1  1=write, 0=read
- dmem_be  in  DATA_W/8  write byte enables
- dmem_addr  in  ADDR_W  dmem word address
- dmem_wdata  in  DATA_W  write data
- dmem_gnt  out  1  dmem request accepted this cycle (combinational)
- dmem_rvalid  out  1  dmem_rdata valid (reads only)
- dmem_rdata  out  DATA_W  dmem read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_be  out  DATA_W/8  RAM byte enables
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset: rst_n is synchronous, active-low; clk is the clock. While rst_n=0 the following are forced 0: imem_gnt, dmem_gnt, mem_en, mem_we and mem_be. At the reset edge, the following are cleared: imem_rvalid, dmem_rvalid, the starvation counter, rd_owner (= NONE), and both held-data registers (rdata outputs read 0).
- Arbitration: combinational, evaluated every cycle, at most one grant per cycle.
  - imem_prio = (starve_cnt == STARVE_MAX).
  - Both req: imem wins if imem_prio, else dmem wins.
  - Single req: that requester wins.
  - No req: mem_en=0.
- Grant: gnt=1 in the same cycle as req. The winner's addr/we/be/wdata are driven on the mem_* ports in that cycle with mem_en=1.
  - For imem: mem_we=0, mem_be all ones.
  - For a dmem read: mem_be all ones.
- No back-pressure from the RAM: every granted access completes. Full throughput is one access per cycle.
- Read-return FSM rd_owner {NONE, IMEM, DMEM}, updated every edge:
  - next = IMEM on an imem grant.
  - next = DMEM on a dmem read grant.
  - next = NONE otherwise (no grant, or a dmem write grant).
  - imem_rvalid = (rd_owner==IMEM); dmem_rvalid = (rd_owner==DMEM).
  - Only a read grant produces rvalid, exactly 1 cycle later. Writes produce no rvalid; gnt is their completion.
- Read data:
  - imem_rdata = imem_rvalid ? mem_rdata : imem_hold. imem_hold captures mem_rdata on each cycle imem_rvalid=1.
  - dmem_rdata uses its own hold register, identically.
  - rdata is therefore stable between returns.
- Starvation counter (4 bits, saturating at STARVE_MAX):
  - Increments when imem_req=1 and imem_gnt=0.
  - Clears to 0 on imem_gnt.
  - Holds when imem_req=0.
- Simultaneous events: dmem write and imem read in the same cycle are serialized; the loser keeps req high and is granted in a later cycle. No read-after-write forwarding is needed, because a dmem write granted in cycle N is visible to any read granted in cycle ≥N+1.
- Requester dropping req without a grant: legal; no RAM access is issued for it.
- Reset mid-operation: a read granted in the cycle where rst_n is sampled low is discarded, and no rvalid follows. mem_en is 0 throughout reset.

Test Plan:
- imem read: RAM[0x010]=0xDEADBEEF; imem_req=1, addr=0x010 for one cycle, no dmem_req -> imem_gnt=1, mem_en=1, mem_addr=0x010 in same cycle; next cycle imem_rvalid=1, imem_rdata=0xDEADBEEF; rdata holds 0xDEADBEEF afterwards with rvalid=0.
- Contention: imem_req and dmem_req (read 0x020, data 0x12345678) both rise in cycle 0 -> dmem_gnt in cycle 0, dmem_rvalid cycle 1 with 0x12345678; imem_gnt cycle 1, imem_rvalid cycle 2.
- Starvation, STARVE_MAX=4: dmem_req and imem_req held high continuously -> dmem granted cycles 0–3; imem granted cycle 4, counter returns to 0; dmem granted cycles 5–8; imem granted cycle 9.
- dmem write: we=1, addr=0x005, be=4'b0011, wdata=0xAABBCCDD over RAM word 0x11111111 -> mem_we=1, mem_be=0011, dmem_gnt=1, no dmem_rvalid. A dmem read of 0x005 next cycle returns 0x1111CCDD.
- Back-to-back: imem_req high with addrs 0,1,2,3 in successive cycles -> imem_gnt every cycle, imem_rvalid cycles 1–4 with RAM[0..3] in order.
- Reset mid-read: imem granted in cycle N, rst_n=0 in cycle N+1 -> imem_rvalid=0 in N+1 and N+2, mem_en=0 while reset is asserted, imem_rdata=0 after reset.
